wbufromhex: RTL and testbench
=============================

# wbufromhex

Transmit-side character encoder for the hex-bus debugging link. It accepts 6-bit payload words, plus explicit newline requests, from the bus packetizer and emits printable ASCII bytes toward the UART transmitter. It performs the inverse of the link's receive-side character decoding. It also breaks long output lines automatically and flushes partial lines after an idle period, so the host terminal always sees complete lines.

## Interface
- LINE_LEN, default 80: number of payload characters per line before a newline is inserted automatically (2..255).
- IDLE_CYCLES, default 1024: idle cycles with a partial line pending before a flush newline is emitted (>=2).
- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_stb  in  1  input word valid.
- i_bits  in  7  bit 6 = newline request; bits 5:0 = payload value (ignored when bit 6 = 1).
- o_busy  out  1  input stall; a word is accepted when i_stb && !o_busy.
- o_stb  out  1  output byte valid.
- o_char  out  8  ASCII byte, bit 7 always 0.
- i_busy  in  1  downstream stall; a byte transfers when o_stb && !i_busy.

## Operation
- Payload map, registered into o_char:
  - 0–9 -> 0x30+v
  - 10–35 -> v+0x37 ('A'–'Z')
  - 36–61 -> v+0x3d ('a'–'z')
  - 62 -> 0x40 '@'
  - 63 -> 0x25 '%'
  - Newline -> 0x0a.
- State:
  - col: column counter, width clog2(LINE_LEN+1).
  - nl_pend: auto-newline pending flag.
  - idle: saturating idle counter, width clog2(IDLE_CYCLES+1).
- o_busy = (o_stb && i_busy) || nl_pend. This is combinational.
- Load slot: every cycle with !o_stb || !i_busy. In a load slot, apply exactly one of the following, in priority order:
  1. nl_pend: o_stb<=1, o_char<=0x0a, col<=0, nl_pend<=0, idle<=0. Input is not accepted in this cycle (o_busy=1).
  2. Accepted newline request with col==0: dropped (no blank lines); o_stb<=0.
  3. Accepted newline request with col!=0: emit 0x0a, col<=0, idle<=0.
  4. Accepted payload: emit mapped char, col<=col+1, idle<=0. If col+1==LINE_LEN, nl_pend<=1.
  5. No input, col!=0, idle==IDLE_CYCLES: flush, i.e. emit 0x0a, col<=0, idle<=0.
  6. Otherwise: o_stb<=0.
- Outside a load slot, o_stb, o_char, col and nl_pend hold.
- Idle counter:
  - Clears on any accepted word and on any emitted newline.
  - Otherwise increments when col!=0, saturating at IDLE_CYCLES.
  - Holds at 0 when col==0.
  - Counts during downstream stalls too; a flush is only issued in a load slot.

## Timing
- Reset values: o_stb=0, o_char=0x00, col=0, nl_pend=0, idle=0, o_busy=0.
- Reset mid-operation discards any held byte and any pending newline. There is no partial-line flush after reset.
- Latency: one cycle from acceptance to o_stb.
- Throughput: one byte per cycle with i_busy=0. Each auto newline costs one extra output slot, during which o_busy=1.
- Output stability: while o_stb && i_busy, o_stb and o_char are held stable.
- Auto newline sequencing: the auto newline appears in the cycle immediately after the LINE_LEN-th char transfers. The next payload is accepted in that same newline-load cycle +1.
- Payload plus flush in the same slot: payload wins, and the idle counter clears.
- Explicit newline arriving while nl_pend=1: the newline request is stalled. It is then dropped, because col==0 after the auto newline.
- i_stb must stay high with i_bits stable while o_busy=1. This is asserted formally as an input assumption.

## Test plan
- Map sweep: feed all 64 payload values back-to-back, LINE_LEN=80, i_busy=0 -> output sequence is '0'..'9','A'..'Z','a'..'z','@','%', each one cycle after acceptance, with no bubbles. No newline appears before the 65th char.
- Line wrap: LINE_LEN=4, feed 6 payloads of value 1 continuously -> outputs "1111\n11". o_busy is high exactly one cycle, on the newline slot.
- Newline suppression: feed newline request, payload 10, newline, newline -> outputs "A\n"; the first and last newline requests are dropped.
- Idle flush: IDLE_CYCLES=8, one payload 5, then i_stb=0 -> '5', then 0x0a exactly when idle reaches 8. After that, no further output indefinitely.
- Backpressure: hold i_busy=1 for 5 cycles with o_stb=1 -> o_char stable, o_busy=1, no input consumed. Release -> the queued byte follows on the next cycle.
- Reset mid-line: reset while nl_pend=1 and o_stb=1 -> next cycle o_stb=0, o_busy=0. The next payload starts a fresh line with col=1.

Source files
------------

// File: rtl/wbufromhex.sv
// Transmit-side character encoder for the hex-bus debug link: maps 6-bit payload
// words to printable ASCII and inserts wrap and idle-flush newlines.
module wbufromhex #(
  parameter int LINE_LEN    = 80,
  parameter int IDLE_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stb,
  input  logic [6:0] i_bits,
  output logic       o_busy,
  output logic       o_stb,
  output logic [7:0] o_char,
  input  logic       i_busy
);

  localparam int COL_W  = $clog2(LINE_LEN + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_LEN);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
  localparam logic [7:0]        NL_CHAR  = 8'h0a;

  // What the output register does this cycle. Wrap, explicit and flush
  // newlines all have the same effect, so they share one action.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_IDLE,
    ACT_NEWLINE,
    ACT_CHAR
  } act_e;

  logic              stb_q,  stb_d;
  logic [7:0]        char_q, char_d;
  logic [COL_W-1:0]  col_q,  col_d;
  logic              pend_q, pend_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic             load;
  logic             accept;
  logic [COL_W-1:0] col_inc;
  act_e             act;

  function automatic logic [7:0] map_char(input logic [5:0] v);
    logic [7:0] w;
    w = {2'b00, v};
    if (v < 6'd10)       return w + 8'h30;
    else if (v < 6'd36)  return w + 8'h37;
    else if (v < 6'd62)  return w + 8'h3d;
    else if (v == 6'd62) return 8'h40;
    else                 return 8'h25;
  endfunction

  assign load    = !stb_q || !i_busy;
  assign o_busy  = (stb_q && i_busy) || pend_q;
  assign accept  = i_stb && !o_busy;
  assign col_inc = col_q + 1'b1;
  assign o_stb   = stb_q;
  assign o_char  = char_q;

  always_comb begin
    act = ACT_HOLD;
    if (load) begin
      if (pend_q)
        act = ACT_NEWLINE;
      else if (accept && i_bits[6])
        act = (col_q == '0) ? ACT_IDLE : ACT_NEWLINE;
      else if (accept)
        act = ACT_CHAR;
      else if (col_q != '0 && idle_q == IDLE_MAX)
        act = ACT_NEWLINE;
      else
        act = ACT_IDLE;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case below can leave one unassigned and infer a latch.
    stb_d  = stb_q;
    char_d = char_q;
    col_d  = col_q;
    pend_d = pend_q;
    case (act)
      ACT_IDLE: stb_d = 1'b0;
      ACT_NEWLINE: begin
        stb_d  = 1'b1;
        char_d = NL_CHAR;
        col_d  = '0;
        pend_d = 1'b0;
      end
      ACT_CHAR: begin
        stb_d  = 1'b1;
        char_d = map_char(i_bits[5:0]);
        col_d  = col_inc;
        pend_d = (col_inc == COL_LAST);
      end
      default: ;
    endcase
  end

  // The idle counter keeps running through downstream stalls; it only acts in a load slot.
  always_comb begin
    idle_d = idle_q;
    if (act == ACT_NEWLINE || accept)
      idle_d = '0;
    else if (col_q != '0 && idle_q != IDLE_MAX)
      idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (i_reset) begin
      stb_q  <= 1'b0;
      char_q <= 8'h00;
      col_q  <= '0;
      pend_q <= 1'b0;
      idle_q <= '0;
    end else begin
      stb_q  <= stb_d;
      char_q <= char_d;
      col_q  <= col_d;
      pend_q <= pend_d;
      idle_q <= idle_d;
    end
  end

endmodule

// File: tb/tb_wbufromhex.sv
// Bench for wbufromhex: exact-cycle vectors on a short-line instance, a map sweep
// on a default-sized instance, and a randomized run against a stream-level model.
module tb_wbufromhex;

  localparam int S_LEN  = 4;
  localparam int S_IDLE = 8;

  logic       clk;
  logic       rst;

  logic       s_stb, s_ibusy, s_obusy, s_ostb;
  logic [6:0] s_bits;
  logic [7:0] s_char;

  logic       l_stb, l_ibusy, l_obusy, l_ostb;
  logic [6:0] l_bits;
  logic [7:0] l_char;

  int errors = 0;
  int checks = 0;

  string map_s;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       stb;
    logic [6:0] bits;
    logic       ib;
    logic       e_stb;
    logic [7:0] e_char;
    logic       e_busy;
  } vec_t;

  vec_t tbl[20];

  wbufromhex #(.LINE_LEN(S_LEN), .IDLE_CYCLES(S_IDLE)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_stb(s_stb), .i_bits(s_bits),
    .o_busy(s_obusy), .o_stb(s_ostb), .o_char(s_char), .i_busy(s_ibusy)
  );

  wbufromhex #(.LINE_LEN(80), .IDLE_CYCLES(1024)) dut_l (
    .i_clk(clk), .i_reset(rst), .i_stb(l_stb), .i_bits(l_bits),
    .o_busy(l_obusy), .o_stb(l_ostb), .o_char(l_char), .i_busy(l_ibusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_stb = 1'b0; s_bits = '0; s_ibusy = 1'b0;
    l_stb = 1'b0; l_bits = '0; l_ibusy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle on the short-line instance: drive, compare before the edge, advance.
  task automatic cyc_s(input string nm, input logic stb, input logic [6:0] bits, input logic ib,
                       input logic e_stb, input logic [7:0] e_char, input logic e_busy);
    s_stb = stb; s_bits = bits; s_ibusy = ib;
    @(negedge clk);
    check({nm, "_stb"}, s_ostb, e_stb);
    if (e_stb) check({nm, "_char"}, s_char, e_char);
    check({nm, "_busy"}, s_obusy, e_busy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       hold, prv_stall, mode;
    logic [7:0] prv_char;
    int         mcol, last_acc;

    map_s = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz@%";

    for (int i = 0; i < 20; i++) begin
      tbl[i].stb    = (i < 7);
      tbl[i].bits   = (i < 7) ? 7'h01 : 7'h00;
      tbl[i].ib     = 1'b0;
      tbl[i].e_stb  = (i >= 1 && i <= 7);
      tbl[i].e_char = 8'h31;
      tbl[i].e_busy = 1'b0;
    end
    tbl[4].e_busy  = 1'b1;
    tbl[5].e_char  = 8'h0a;
    tbl[16].e_stb  = 1'b1;
    tbl[16].e_char = 8'h0a;

    do_reset();
    @(negedge clk);
    check("rst_stb",  s_ostb,  0);
    check("rst_char", s_char,  8'h00);
    check("rst_busy", s_obusy, 0);
    check("rst_l_stb",  l_ostb,  0);
    check("rst_l_char", l_char,  8'h00);
    @(posedge clk);
    #1;

    // All 64 payload values back to back on the 80-column instance.
    for (int k = 0; k <= 65; k++) begin
      l_stb  = (k < 64);
      l_bits = (k < 64) ? 7'(k) : 7'h00;
      @(negedge clk);
      if (k > 0 && k <= 64) begin
        check("sweep_stb",  l_ostb, 1);
        check("sweep_char", l_char, map_s[k-1]);
      end else begin
        check("sweep_idle", l_ostb, 0);
      end
      check("sweep_busy", l_obusy, 0);
      @(posedge clk);
      #1;
    end

    // Wrap after four chars, then idle flush.
    for (int i = 0; i < 20; i++)
      cyc_s($sformatf("tbl%0d", i), tbl[i].stb, tbl[i].bits, tbl[i].ib,
            tbl[i].e_stb, tbl[i].e_char, tbl[i].e_busy);
    repeat (30) cyc_s("quiet", 0, 7'h00, 0, 0, 8'h00, 0);

    cyc_s("nl_drop1", 1, 7'h40, 0, 0, 8'h00, 0);
    cyc_s("nl_pay",   1, 7'd10, 0, 0, 8'h00, 0);
    cyc_s("nl_emit",  1, 7'h40, 0, 1, 8'h41, 0);
    cyc_s("nl_drop2", 1, 7'h40, 0, 1, 8'h0a, 0);
    repeat (3) cyc_s("nl_quiet", 0, 7'h00, 0, 0, 8'h00, 0);

    cyc_s("bp_in", 1, 7'd5, 0, 0, 8'h00, 0);
    repeat (5) cyc_s("bp_stall", 1, 7'd6, 1, 1, 8'h35, 1);
    cyc_s("bp_release", 1, 7'd6, 0, 1, 8'h35, 0);
    cyc_s("bp_next", 0, 7'h00, 0, 1, 8'h36, 0);
    cyc_s("bp_done", 0, 7'h00, 0, 0, 8'h00, 0);

    cyc_s("rst_a", 1, 7'd62, 0, 0, 8'h00, 0);
    cyc_s("rst_b", 1, 7'd63, 0, 1, 8'h40, 0);
    rst = 1'b1;
    cyc_s("rst_pend", 0, 7'h00, 1, 1, 8'h25, 1);
    rst = 1'b0;
    cyc_s("rst_clear", 0, 7'h00, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc_s("rst_line", 1, 7'd9, 0, (i > 0), 8'h39, 0);
    cyc_s("rst_wrap", 1, 7'd9, 0, 1, 8'h39, 1);
    cyc_s("rst_nl",   1, 7'd9, 0, 1, 8'h0a, 0);
    cyc_s("rst_tail", 0, 7'h00, 0, 1, 8'h39, 0);

    do_reset();
    cyc_s("flush_in", 1, 7'd5, 0, 0, 8'h00, 0);
    for (int n = 1; n <= 9; n++) cyc_s("flush_wait", 0, 7'h00, 0, (n == 1), 8'h35, 0);
    cyc_s("flush_nl", 0, 7'h00, 0, 1, 8'h0a, 0);
    repeat (40) cyc_s("flush_quiet", 0, 7'h00, 0, 0, 8'h00, 0);

    // Idle count saturates during a long stall; the flush lands in the first load slot.
    cyc_s("sat_in", 1, 7'd35, 0, 0, 8'h00, 0);
    repeat (20) cyc_s("sat_stall", 0, 7'h00, 1, 1, 8'h5a, 1);
    cyc_s("sat_release", 0, 7'h00, 0, 1, 8'h5a, 0);
    cyc_s("sat_flush",   0, 7'h00, 0, 1, 8'h0a, 0);
    cyc_s("sat_after",   0, 7'h00, 0, 0, 8'h00, 0);

    // A payload offered in the flush slot wins and restarts the idle count.
    cyc_s("win_in", 1, 7'd35, 0, 0, 8'h00, 0);
    repeat (20) cyc_s("win_stall", 0, 7'h00, 1, 1, 8'h5a, 1);
    cyc_s("win_payload", 1, 7'd36, 0, 1, 8'h5a, 0);
    cyc_s("win_char", 0, 7'h00, 0, 1, 8'h61, 0);
    repeat (8) cyc_s("win_idle", 0, 7'h00, 0, 0, 8'h00, 0);
    cyc_s("win_flush", 0, 7'h00, 0, 1, 8'h0a, 0);

    // Randomized traffic against a byte-stream model.
    do_reset();
    hold = 1'b0; prv_stall = 1'b0; prv_char = 8'h00;
    mcol = 0; last_acc = 0; mode = 1'b1;
    for (int cyc = 0; cyc < 2040; cyc++) begin
      if (!hold) begin
        if (cyc % 64 == 0) mode = 1'($urandom_range(0, 1));
        s_stb = (cyc < 2000) && ($urandom_range(0, 99) < (mode ? 70 : 4));
        if (!s_stb)                        s_bits = 7'h00;
        else if ($urandom_range(0, 7) == 0) s_bits = {1'b1, 6'($urandom)};
        else                               s_bits = {1'b0, 6'($urandom)};
      end
      s_ibusy = (cyc < 2000) && ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (prv_stall) begin
        check("rnd_hold_stb",  s_ostb, 1);
        check("rnd_hold_char", s_char, prv_char);
      end
      if (s_ostb) check("rnd_bit7", s_char[7], 0);
      if (s_ostb && !s_ibusy) begin
        if (exp_q.size() > 0) begin
          check("rnd_byte", s_char, exp_q.pop_front());
        end else begin
          check("rnd_flush_char", s_char, 8'h0a);
          check("rnd_flush_col", (mcol != 0), 1);
          check("rnd_flush_time", ((cyc - last_acc) >= S_IDLE + 2), 1);
          mcol = 0;
        end
      end
      if (s_stb && !s_obusy) begin
        last_acc = cyc;
        if (s_bits[6]) begin
          if (mcol != 0) begin
            exp_q.push_back(8'h0a);
            mcol = 0;
          end
        end else begin
          exp_q.push_back(map_s[int'(s_bits[5:0])]);
          mcol++;
          if (mcol == S_LEN) begin
            exp_q.push_back(8'h0a);
            mcol = 0;
          end
        end
      end
      hold      = s_stb && s_obusy;
      prv_stall = s_ostb && s_ibusy;
      prv_char  = s_char;
      @(posedge clk);
      #1;
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_line_closed", mcol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
